// File: rtl/pfa_out_agu.sv
// pfa_out_agu: output-side address generator for the two-factor PFA FFT.
// Walks the linear output index k = 0..N-1 (N = M1*M2) in order, up to four
// lanes per beat, and gives each lane its CRT residues k mod M1 and k mod M2
// so that the bank memories can be read back in natural output order.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-high reset
//   start           one-cycle pulse, starts a sequence when idle
//   M1, M2          PFA factors, sampled on an accepted start
//   lanes_m1        lanes per beat minus one (P = lanes_m1 + 1), sampled on start
//   out_ready       downstream accepts the current beat
//   out_valid       beat present
//   k_out           linear index of lane 0
//   k1_out_0..3     k mod M1 per lane
//   k2_out_0..3     k mod M2 per lane
//   lane_valid      per-lane valid (lane enabled and index below N)
//   busy            high while the sequence runs
//   done            one-cycle pulse at sequence end
module pfa_out_agu #(
  parameter int IDX_W = 8,
  parameter int K_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] M1,
  input  logic [IDX_W-1:0] M2,
  input  logic [1:0]       lanes_m1,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [K_W-1:0]   k_out,
  output logic [IDX_W-1:0] k1_out_0,
  output logic [IDX_W-1:0] k1_out_1,
  output logic [IDX_W-1:0] k1_out_2,
  output logic [IDX_W-1:0] k1_out_3,
  output logic [IDX_W-1:0] k2_out_0,
  output logic [IDX_W-1:0] k2_out_1,
  output logic [IDX_W-1:0] k2_out_2,
  output logic [IDX_W-1:0] k2_out_3,
  output logic [3:0]       lane_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] m1_r, m2_r;
  logic [IDX_W-1:0] b1_r, b2_r;
  logic [K_W-1:0]   k_r, n_r;
  logic [1:0]       pm1_r;

  logic [IDX_W-1:0] r1 [4];
  logic [IDX_W-1:0] r2 [4];
  logic             run, xfer, last;
  logic [3:0]       lv;

  // Residue increment that wraps to zero when it reaches the modulus. The
  // extra bit keeps v+1 from aliasing when the modulus sits at the top of range.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v,
                                                input logic [IDX_W-1:0] m);
    logic [IDX_W:0] s;
    s = {1'b0, v} + {{IDX_W{1'b0}}, 1'b1};
    return (s == {1'b0, m}) ? '0 : s[IDX_W-1:0];
  endfunction

  assign run  = (state == RUN);
  assign xfer = run && out_ready;

  // Chained residue incrementers: each lane is the previous lane plus one,
  // modulo the latched factor, so factors smaller than P stay correct.
  always_comb begin
    logic [IDX_W-1:0] t1, t2;
    t1 = b1_r;
    t2 = b2_r;
    r1[0] = t1;
    r2[0] = t2;
    for (int i = 1; i < 4; i++) begin
      t1 = wrap_inc(t1, m1_r);
      t2 = wrap_inc(t2, m2_r);
      r1[i] = t1;
      r2[i] = t2;
    end
  end

  // Index compares run one bit wider so k + P cannot overflow.
  always_comb begin
    last = (({1'b0, k_r} + (K_W+1)'(pm1_r) + (K_W+1)'(1)) >= {1'b0, n_r});
    lv   = '0;
    for (int i = 0; i < 4; i++) begin
      lv[i] = run && (2'(i) <= pm1_r) &&
              (({1'b0, k_r} + (K_W+1)'(i)) < {1'b0, n_r});
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = ((M1 == '0) || (M2 == '0)) ? DONE : RUN;
      RUN:  if (xfer && last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequence registers: latched on start, advanced by one beat per transfer.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m1_r  <= '0;
      m2_r  <= '0;
      pm1_r <= '0;
      n_r   <= '0;
      k_r   <= '0;
      b1_r  <= '0;
      b2_r  <= '0;
    end else if ((state == IDLE) && start) begin
      m1_r  <= M1;
      m2_r  <= M2;
      pm1_r <= lanes_m1;
      n_r   <= K_W'(M1) * K_W'(M2);
      k_r   <= '0;
      b1_r  <= '0;
      b2_r  <= '0;
    end else if (xfer) begin
      k_r  <= k_r + K_W'(pm1_r) + K_W'(1);
      b1_r <= wrap_inc(r1[pm1_r], m1_r);
      b2_r <= wrap_inc(r2[pm1_r], m2_r);
    end
  end

  // Outputs from registered state only; everything reads zero outside RUN.
  always_comb begin
    out_valid  = run;
    busy       = run;
    done       = (state == DONE);
    k_out      = run ? k_r : '0;
    lane_valid = lv;
    k1_out_0   = run                    ? r1[0] : '0;
    k1_out_1   = (run && (pm1_r >= 2'd1)) ? r1[1] : '0;
    k1_out_2   = (run && (pm1_r >= 2'd2)) ? r1[2] : '0;
    k1_out_3   = (run && (pm1_r == 2'd3)) ? r1[3] : '0;
    k2_out_0   = run                    ? r2[0] : '0;
    k2_out_1   = (run && (pm1_r >= 2'd1)) ? r2[1] : '0;
    k2_out_2   = (run && (pm1_r >= 2'd2)) ? r2[2] : '0;
    k2_out_3   = (run && (pm1_r == 2'd3)) ? r2[3] : '0;
  end

endmodule

// File: tb/tb_pfa_out_agu.sv
// Testbench for pfa_out_agu: a scoreboard of expected beats is filled from a
// modular-arithmetic model when a sequence starts and drained as the DUT
// transfers beats.
module tb_pfa_out_agu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  M1 = '0, M2 = '0;
  logic [1:0]  lanes_m1 = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] k_out;
  logic [7:0]  k1_out_0, k1_out_1, k1_out_2, k1_out_3;
  logic [7:0]  k2_out_0, k2_out_1, k2_out_2, k2_out_3;
  logic [3:0]  lane_valid;
  logic        busy, done;

  typedef struct packed {
    logic [15:0] k;
    logic [3:0]  lv;
    logic [31:0] k1;
    logic [31:0] k2;
  } beat_t;

  beat_t q[$];
  int    n_chk = 0;
  int    n_pass = 0;

  pfa_out_agu #(.IDX_W(8), .K_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M1(M1), .M2(M2),
    .lanes_m1(lanes_m1), .out_ready(out_ready), .out_valid(out_valid),
    .k_out(k_out),
    .k1_out_0(k1_out_0), .k1_out_1(k1_out_1), .k1_out_2(k1_out_2), .k1_out_3(k1_out_3),
    .k2_out_0(k2_out_0), .k2_out_1(k2_out_1), .k2_out_2(k2_out_2), .k2_out_3(k2_out_3),
    .lane_valid(lane_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic beat_t sample();
    beat_t b;
    b.k  = k_out;
    b.lv = lane_valid;
    b.k1 = {k1_out_3, k1_out_2, k1_out_1, k1_out_0};
    b.k2 = {k2_out_3, k2_out_2, k2_out_1, k2_out_0};
    return b;
  endfunction

  task automatic check_idle_outputs(input string tag);
    beat_t b;
    b = sample();
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_k"}, 32'(b.k), 0);
    check({tag, "_lv"}, 32'(b.lv), 0);
    check({tag, "_k1"}, b.k1, 0);
    check({tag, "_k2"}, b.k2, 0);
  endtask

  // Model: lane i of the beat at index k carries (k+i) mod M for every enabled
  // lane; disabled lanes read zero.
  task automatic push_expected(input int m1, input int m2, input int p);
    int n;
    beat_t e;
    n = m1 * m2;
    for (int k = 0; k < n; k += p) begin
      e = '0;
      e.k = 16'(k);
      for (int i = 0; i < 4; i++) begin
        if (i < p) begin
          e.k1[8*i +: 8] = 8'((k + i) % m1);
          e.k2[8*i +: 8] = 8'((k + i) % m2);
          e.lv[i] = ((k + i) < n);
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic run_seq(input int m1, input int m2, input int p,
                         input int stall_beat, input int stall_len,
                         input bit start_mid);
    int n, nbeats, cyc, bidx, scnt, exp_done;
    bit got_done;
    beat_t cur, snap, e;
    string tg;
    n = m1 * m2;
    nbeats = (n + p - 1) / p;
    exp_done = nbeats + 1 + ((stall_beat >= 0 && stall_beat < nbeats) ? stall_len : 0);
    push_expected(m1, m2, p);
    @(negedge clk);
    start = 1'b1; M1 = 8'(m1); M2 = 8'(m2); lanes_m1 = 2'(p - 1); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; bidx = 0; scnt = 0; got_done = 0;
    snap = '0;
    while (!got_done && cyc < 300) begin
      out_ready = !(bidx == stall_beat && scnt < stall_len);
      if (start_mid && cyc == 3) begin
        start = 1'b1; M1 = 8'd1; M2 = 8'd1; lanes_m1 = 2'd3;
      end else if (start_mid && cyc == 4) begin
        start = 1'b0; M1 = 8'(m1); M2 = 8'(m2); lanes_m1 = 2'(p - 1);
      end
      #1;
      cur = sample();
      tg = $sformatf("m%0dx%0d_p%0d_c%0d", m1, m2, p, cyc);
      check({tg, "_busy"}, 32'(busy), 32'(out_valid));
      if (out_valid && !out_ready) begin
        if (scnt == 0) snap = cur;
        else begin
          check({tg, "_stall_k"}, 32'(cur.k), 32'(snap.k));
          check({tg, "_stall_lv"}, 32'(cur.lv), 32'(snap.lv));
          check({tg, "_stall_k1"}, cur.k1, snap.k1);
          check({tg, "_stall_k2"}, cur.k2, snap.k2);
        end
        scnt++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check({tg, "_extra_beat"}, 1, 0);
        else begin
          e = q.pop_front();
          tg = $sformatf("m%0dx%0d_p%0d_b%0d", m1, m2, p, bidx);
          check({tg, "_k"}, 32'(cur.k), 32'(e.k));
          check({tg, "_lv"}, 32'(cur.lv), 32'(e.lv));
          check({tg, "_k1"}, cur.k1, e.k1);
          check({tg, "_k2"}, cur.k2, e.k2);
        end
        bidx++;
      end
      if (done) begin
        got_done = 1;
        check({tg, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        check_idle_outputs({tg, "_at_done"});
        check({tg, "_sb_empty"}, 32'(q.size()), 0);
      end else if (!out_valid) begin
        check_idle_outputs({tg, "_no_beat"});
      end
      @(negedge clk);
      cyc++;
    end
    if (!got_done) begin
      check($sformatf("m%0dx%0d_p%0d_timeout", m1, m2, p), 0, 1);
      q.delete();
    end
    #1;
    check($sformatf("m%0dx%0d_p%0d_done_pulse", m1, m2, p), 32'(done), 0);
    check($sformatf("m%0dx%0d_p%0d_after_valid", m1, m2, p), 32'(out_valid), 0);
  endtask

  initial begin
    // Reset state
    #12;
    check_idle_outputs("reset");
    check("reset_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b0;

    run_seq(3, 4, 1, -1, 0, 0);
    run_seq(5, 7, 4, -1, 0, 0);
    run_seq(3, 4, 2, 3, 5, 0);
    run_seq(2, 3, 4, -1, 0, 0);
    run_seq(4, 0, 2, -1, 0, 0);
    run_seq(1, 1, 3, -1, 0, 0);
    run_seq(1, 5, 4, 1, 2, 0);
    run_seq(3, 5, 2, -1, 0, 1);

    // Reset in the middle of a sequence
    @(negedge clk);
    start = 1'b1; M1 = 8'd5; M2 = 8'd7; lanes_m1 = 2'd0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("midrun_valid_before_reset", 32'(out_valid), 1);
    #1;
    rst_n = 1'b1;
    #1;
    check_idle_outputs("midrun_reset");
    check("midrun_reset_done", 32'(done), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("reset_hold%0d_done", i), 32'(done), 0);
      check($sformatf("reset_hold%0d_valid", i), 32'(out_valid), 0);
    end
    rst_n = 1'b0;
    run_seq(3, 4, 1, -1, 0, 0);

    // A few randomised sequences with a short stall
    for (int t = 0; t < 4; t++) begin
      run_seq($urandom_range(1, 9), $urandom_range(0, 9), $urandom_range(1, 4),
              $urandom_range(0, 5), $urandom_range(1, 3), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
